// File: rtl/sram_dp_bwe_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_dp_bwe_ctl
//  Purpose  : True dual-port, single-clock, byte-write RAM with selectable
//             same-port read-during-write mode, 1- or 2-cycle read latency
//             with per-port read-valid, cross-port write-collision
//             resolution (port A wins overlapping lanes) and a reset-time
//             memory clear sequencer.
//  Ports    : clka            clock
//             rst             synchronous active-high reset
//             ena/enb         port enable
//             wea/web         per-lane write enable (qualified by enable)
//             addra/addrb     word address
//             dina/dinb       write data
//             regcea/regceb   output-register load enable (OUT_REG=1)
//             douta/doutb     read data
//             vala/valb       read data is from a completed read
//             collision       one-cycle pulse after an overlapping-lane
//                             same-address write by both ports
//             busy            memory clear in progress, ports ignored
//  Revision : 1.0  initial release
// ============================================================================
module sram_dp_bwe_ctl #(
   parameter int    NB_COL         = 4,
   parameter int    COL_WIDTH      = 8,
   parameter int    RAM_DEPTH      = 2048,
   parameter string RD_MODE        = "READ_FIRST",
   parameter int    OUT_REG        = 0,
   parameter int    CLEAR_ON_RESET = 1,
   localparam int   W              = NB_COL * COL_WIDTH,
   localparam int   AW             = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              ena,
   input  logic              enb,
   input  logic [NB_COL-1:0] wea,
   input  logic [NB_COL-1:0] web,
   input  logic [AW-1:0]     addra,
   input  logic [AW-1:0]     addrb,
   input  logic [W-1:0]      dina,
   input  logic [W-1:0]      dinb,
   input  logic              regcea,
   input  logic              regceb,
   output logic [W-1:0]      douta,
   output logic [W-1:0]      doutb,
   output logic              vala,
   output logic              valb,
   output logic              collision,
   output logic              busy
);

   localparam bit          c_WF        = (RD_MODE == "WRITE_FIRST");
   localparam bit          c_NC        = (RD_MODE == "NO_CHANGE");
   localparam logic [AW:0] c_DEPTH_EXT = (AW+1)'(RAM_DEPTH);
   localparam logic [AW-1:0] c_LAST    = AW'(RAM_DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t              r_state;
   logic [AW-1:0]       r_clr_addr;
   logic                r_busy;
   logic                r_coll;
   logic [W-1:0]        r_mem [RAM_DEPTH];

   logic                w_ready;
   logic [1:0]          w_en;
   logic [1:0]          w_regce;
   logic [1:0]          w_inr;
   logic [NB_COL-1:0]   w_we   [2];
   logic [AW-1:0]       w_addr [2];
   logic [W-1:0]        w_din  [2];
   logic [W-1:0]        w_dout [2];
   logic [1:0]          w_val;
   logic                w_same;
   logic [NB_COL-1:0]   w_lane_a;
   logic [NB_COL-1:0]   w_lane_braw;
   logic [NB_COL-1:0]   w_lane_b;
   logic                w_coll;

   assign w_ready   = (r_state == S_READY);
   assign w_en      = {enb, ena};
   assign w_regce   = {regceb, regcea};
   assign w_we[0]   = wea;
   assign w_we[1]   = web;
   assign w_addr[0] = addra;
   assign w_addr[1] = addrb;
   assign w_din[0]  = dina;
   assign w_din[1]  = dinb;

   // Out-of-range addresses (non-power-of-2 depth) never touch the array.
   assign w_inr[0]  = ({1'b0, addra} < c_DEPTH_EXT);
   assign w_inr[1]  = ({1'b0, addrb} < c_DEPTH_EXT);

   // Effective write lanes. B loses any lane A also writes at the same word.
   assign w_same      = (addra == addrb);
   assign w_lane_a    = (w_ready && ena && w_inr[0]) ? wea : '0;
   assign w_lane_braw = (w_ready && enb && w_inr[1]) ? web : '0;
   assign w_lane_b    = w_lane_braw & ~(w_same ? w_lane_a : '0);
   assign w_coll      = w_same && (|(w_lane_a & w_lane_braw));

   // ------------------------------------------------------------------
   // Clear sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (rst) begin
         r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         r_clr_addr <= '0;
         r_busy     <= (CLEAR_ON_RESET != 0);
      end else if (r_state == S_CLEAR) begin
         if (r_clr_addr == c_LAST) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
         end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Array writes (clear or user). Reset leaves contents untouched.
   // ------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (!rst) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
         end else begin
            for (int i = 0; i < NB_COL; i++) begin
               if (w_lane_a[i])
                  r_mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
               if (w_lane_b[i])
                  r_mem[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clka) begin
      if (rst) r_coll <= 1'b0;
      else     r_coll <= w_coll;
   end

   // ------------------------------------------------------------------
   // Per-port read pipeline
   // ------------------------------------------------------------------
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [W-1:0] w_old;
      logic [W-1:0] w_rdata;
      logic [W-1:0] r_s1d;
      logic         r_s1v;
      logic [W-1:0] r_s2d;
      logic         r_s2v;

      // Array read happens before this cycle's writes land, so a cross-port
      // reader always sees the old word.
      assign w_old = w_inr[p] ? r_mem[w_addr[p]] : '0;

      always_comb begin
         w_rdata = w_old;
         if (c_WF && w_inr[p]) begin
            for (int i = 0; i < NB_COL; i++) begin
               if (w_we[p][i])
                  w_rdata[i*COL_WIDTH +: COL_WIDTH] = w_din[p][i*COL_WIDTH +: COL_WIDTH];
            end
         end
      end

      always_ff @(posedge clka) begin
         if (rst) begin
            r_s1d <= '0;
            r_s1v <= 1'b0;
         end else if (!w_ready || !w_en[p]) begin
            r_s1v <= 1'b0;
         end else if (c_NC && (|w_we[p])) begin
            r_s1v <= 1'b0;
         end else begin
            r_s1d <= w_rdata;
            r_s1v <= 1'b1;
         end
      end

      // Second stage is only observed when OUT_REG is set.
      always_ff @(posedge clka) begin
         if (rst) begin
            r_s2d <= '0;
            r_s2v <= 1'b0;
         end else if (w_regce[p]) begin
            r_s2d <= r_s1d;
            r_s2v <= r_s1v;
         end
      end

      assign w_dout[p] = (OUT_REG != 0) ? r_s2d : r_s1d;
      assign w_val[p]  = (OUT_REG != 0) ? r_s2v : r_s1v;
   end

   assign douta     = w_dout[0];
   assign doutb     = w_dout[1];
   assign vala      = w_val[0];
   assign valb      = w_val[1];
   assign collision = r_coll;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_bwe_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_dp_bwe_ctl
//  Purpose  : Self-checking bench for sram_dp_bwe_ctl. Four instances share
//             the stimulus: READ_FIRST, WRITE_FIRST, NO_CHANGE (depth 16,
//             OUT_REG=0) and READ_FIRST with OUT_REG=1 at depth 10. A
//             behavioural model of each configuration predicts every output
//             after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_dp_bwe_ctl;

   localparam int N = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        ena = 1'b0, enb = 1'b0, regcea = 1'b1, regceb = 1'b1;
   logic [3:0]  wea = '0, web = '0, addra = '0, addrb = '0;
   logic [31:0] dina = '0, dinb = '0;

   logic [31:0] douta [N];
   logic [31:0] doutb [N];
   logic        vala  [N];
   logic        valb  [N];
   logic        coll  [N];
   logic        busy  [N];

   sram_dp_bwe_ctl #(.RAM_DEPTH(16), .RD_MODE("READ_FIRST"), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rf (
      .clka(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .regcea(regcea), .regceb(regceb), .douta(douta[0]), .doutb(doutb[0]),
      .vala(vala[0]), .valb(valb[0]), .collision(coll[0]), .busy(busy[0]));

   sram_dp_bwe_ctl #(.RAM_DEPTH(16), .RD_MODE("WRITE_FIRST"), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_wf (
      .clka(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .regcea(regcea), .regceb(regceb), .douta(douta[1]), .doutb(doutb[1]),
      .vala(vala[1]), .valb(valb[1]), .collision(coll[1]), .busy(busy[1]));

   sram_dp_bwe_ctl #(.RAM_DEPTH(16), .RD_MODE("NO_CHANGE"), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_nc (
      .clka(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .regcea(regcea), .regceb(regceb), .douta(douta[2]), .doutb(doutb[2]),
      .vala(vala[2]), .valb(valb[2]), .collision(coll[2]), .busy(busy[2]));

   sram_dp_bwe_ctl #(.RAM_DEPTH(10), .RD_MODE("READ_FIRST"), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_or (
      .clka(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
      .regcea(regcea), .regceb(regceb), .douta(douta[3]), .doutb(doutb[3]),
      .vala(vala[3]), .valb(valb[3]), .collision(coll[3]), .busy(busy[3]));

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   function automatic int depth_of(int c);  return (c == 3) ? 10 : 16; endfunction
   function automatic int mode_of(int c);   return (c == 1) ? 1 : (c == 2) ? 2 : 0; endfunction
   function automatic bit oreg_of(int c);   return (c == 3); endfunction

   function automatic logic [31:0] merge(logic [31:0] base, logic [31:0] d, logic [3:0] lanes);
      logic [31:0] r;
      r = base;
      for (int l = 0; l < 4; l++)
         if (lanes[l]) r[8*l +: 8] = d[8*l +: 8];
      return r;
   endfunction

   logic [31:0] m_mem [N][16];
   logic [31:0] m_s1d [N][2];
   logic [31:0] m_s2d [N][2];
   bit          m_s1v [N][2];
   bit          m_s2v [N][2];
   bit          m_coll[N];
   int          m_busy[N];

   int checks = 0;
   int errors = 0;
   int bcnt [N];

   task automatic model_step();
      bit          e  [2];
      logic [3:0]  w  [2];
      int          ad [2];
      logic [31:0] di [2];
      bit          rc [2];
      logic [31:0] old [16];
      logic [31:0] rd;
      int          dep;
      e[0] = ena;   e[1] = enb;   w[0] = wea;   w[1] = web;
      ad[0] = int'(addra); ad[1] = int'(addrb);
      di[0] = dina; di[1] = dinb; rc[0] = regcea; rc[1] = regceb;
      for (int c = 0; c < N; c++) begin
         dep = depth_of(c);
         if (rst) begin
            for (int p = 0; p < 2; p++) begin
               m_s1d[c][p] = '0; m_s1v[c][p] = 0; m_s2d[c][p] = '0; m_s2v[c][p] = 0;
            end
            m_coll[c] = 0;
            m_busy[c] = dep;
         end else begin
            for (int p = 0; p < 2; p++)
               if (rc[p]) begin m_s2d[c][p] = m_s1d[c][p]; m_s2v[c][p] = m_s1v[c][p]; end
            if (m_busy[c] > 0) begin
               m_mem[c][dep - m_busy[c]] = '0;
               m_busy[c]--;
               m_s1v[c][0] = 0; m_s1v[c][1] = 0;
               m_coll[c] = 0;
            end else begin
               for (int i = 0; i < 16; i++) old[i] = m_mem[c][i];
               for (int p = 0; p < 2; p++) begin
                  if (!e[p]) m_s1v[c][p] = 0;
                  else if (w[p] != 0 && mode_of(c) == 2) m_s1v[c][p] = 0;
                  else begin
                     rd = (ad[p] < dep) ? old[ad[p]] : 32'h0;
                     if (mode_of(c) == 1 && w[p] != 0 && ad[p] < dep) rd = merge(rd, di[p], w[p]);
                     m_s1d[c][p] = rd;
                     m_s1v[c][p] = 1;
                  end
               end
               // B lands first, A on top: A owns any lane both write.
               for (int p = 1; p >= 0; p--)
                  if (e[p] && ad[p] < dep) m_mem[c][ad[p]] = merge(m_mem[c][ad[p]], di[p], w[p]);
               m_coll[c] = e[0] && e[1] && (ad[0] == ad[1]) && (ad[0] < dep) && ((w[0] & w[1]) != 0);
            end
         end
      end
   endtask

   task automatic chk(string tag, int c, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   task automatic compare_all();
      for (int c = 0; c < N; c++) begin
         chk("douta", c, douta[c], oreg_of(c) ? m_s2d[c][0] : m_s1d[c][0]);
         chk("doutb", c, doutb[c], oreg_of(c) ? m_s2d[c][1] : m_s1d[c][1]);
         chk("vala",  c, 32'(vala[c]), 32'(oreg_of(c) ? m_s2v[c][0] : m_s1v[c][0]));
         chk("valb",  c, 32'(valb[c]), 32'(oreg_of(c) ? m_s2v[c][1] : m_s1v[c][1]));
         chk("collision", c, 32'(coll[c]), 32'(m_coll[c]));
         chk("busy",  c, 32'(busy[c]), 32'(m_busy[c] > 0));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < N; c++) bcnt[c] += (busy[c] === 1'b1) ? 1 : 0;
      compare_all();
   endtask

   task automatic idle();
      ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
   endtask

   task automatic port_a(logic en, logic [3:0] we, logic [3:0] ad, logic [31:0] d);
      ena = en; wea = we; addra = ad; dina = d;
   endtask

   task automatic port_b(logic en, logic [3:0] we, logic [3:0] ad, logic [31:0] d);
      enb = en; web = we; addrb = ad; dinb = d;
   endtask

   task automatic rand_cycle();
      ena    = 1'($urandom_range(0, 1));
      enb    = 1'($urandom_range(0, 1));
      wea    = 4'($urandom_range(0, 15));
      web    = 4'($urandom_range(0, 15));
      addra  = 4'($urandom_range(0, 15));
      addrb  = ($urandom_range(0, 3) == 0) ? addra : 4'($urandom_range(0, 15));
      dina   = $urandom;
      dinb   = $urandom;
      regcea = ($urandom_range(0, 3) != 0);
      regceb = ($urandom_range(0, 3) != 0);
      cyc();
   endtask

   initial begin
      for (int c = 0; c < N; c++) begin
         bcnt[c] = 0;
         m_busy[c] = 0;
         for (int i = 0; i < 16; i++) m_mem[c][i] = '0;
      end

      // Reset for two cycles, then count busy cycles.
      rst = 1'b1; idle();
      cyc();
      for (int c = 0; c < N; c++) bcnt[c] = 0;
      cyc();
      chk("rst_busy", 0, 32'(busy[0]), 32'd1);
      chk("rst_douta", 3, douta[3], 32'h0);
      rst = 1'b0;
      // Traffic during the clear must have no effect.
      for (int k = 0; k < 6; k++) begin
         port_a(1'b1, 4'hF, 4'($urandom_range(0, 15)), $urandom);
         port_b(1'b1, 4'hF, 4'($urandom_range(0, 15)), $urandom);
         cyc();
      end
      idle();
      for (int k = 0; k < 14; k++) cyc();
      chk("busy_len16", 0, bcnt[0], 32'd16);
      chk("busy_len10", 3, bcnt[3], 32'd10);

      // Every address reads back zero after the clear.
      for (int i = 0; i < 16; i++) begin
         port_a(1'b1, 4'h0, 4'(i), '0);
         port_b(1'b1, 4'h0, 4'(15 - i), '0);
         cyc();
         chk("clr_read", 0, douta[0], 32'h0);
      end
      idle(); cyc();

      // Same-port read-during-write.
      port_a(1'b1, 4'hF, 4'd5, 32'h11223344); cyc();
      port_a(1'b1, 4'h3, 4'd5, 32'hAABBCCDD); cyc();
      chk("rf_rdw", 0, douta[0], 32'h11223344);
      chk("rf_rdw_val", 0, 32'(vala[0]), 32'd1);
      chk("wf_rdw", 1, douta[1], 32'h1122CCDD);
      chk("nc_rdw_val", 2, 32'(vala[2]), 32'd0);
      port_a(1'b1, 4'h0, 4'd5, '0); cyc();
      chk("rf_after", 0, douta[0], 32'h1122CCDD);
      idle(); cyc();

      // Cross-port collision and cross-port read.
      port_a(1'b1, 4'hF, 4'd9, 32'h01010101);
      port_b(1'b1, 4'hC, 4'd9, 32'h02020202);
      cyc();
      chk("coll_pulse", 0, 32'(coll[0]), 32'd1);
      idle(); cyc();
      chk("coll_clear", 0, 32'(coll[0]), 32'd0);
      port_a(1'b1, 4'h0, 4'd9, '0); cyc();
      chk("coll_word", 0, douta[0], 32'h01010101);
      port_a(1'b1, 4'hF, 4'd9, 32'h03030303);
      port_b(1'b1, 4'h0, 4'd9, '0);
      cyc();
      chk("xport_rf", 0, doutb[0], 32'h01010101);
      chk("xport_wf", 1, doutb[1], 32'h01010101);
      chk("xport_nocoll", 0, 32'(coll[0]), 32'd0);
      idle(); cyc();

      // Output register: latency 2 and regce freeze.
      regcea = 1'b1;
      port_a(1'b1, 4'hF, 4'd3, 32'h33333333); cyc();
      idle(); cyc(); cyc();
      port_a(1'b1, 4'h0, 4'd3, '0); cyc();
      chk("oreg_lat1", 3, 32'(vala[3]), 32'd0);
      idle(); cyc();
      chk("oreg_lat2", 3, douta[3], 32'h33333333);
      chk("oreg_lat2_val", 3, 32'(vala[3]), 32'd1);
      port_a(1'b1, 4'hF, 4'd4, 32'h44444444); cyc();
      idle(); cyc(); cyc();
      regcea = 1'b0;
      for (int k = 0; k < 3; k++) begin
         port_a(1'b1, 4'h0, 4'd4, '0); cyc();
         chk("oreg_hold", 3, douta[3], 32'h0);
         chk("oreg_hold_val", 3, 32'(vala[3]), 32'd0);
      end
      regcea = 1'b1; idle(); cyc();
      chk("oreg_rel", 3, douta[3], 32'h44444444);
      chk("oreg_rel_val", 3, 32'(vala[3]), 32'd1);

      // Out-of-range access on the depth-10 instance.
      port_a(1'b1, 4'hF, 4'd12, 32'hDEADBEEF); cyc();
      port_a(1'b1, 4'h0, 4'd12, '0); cyc();
      idle(); cyc();
      chk("oob_data", 3, douta[3], 32'h0);
      chk("oob_val", 3, 32'(vala[3]), 32'd1);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) rand_cycle();
      idle(); regcea = 1'b1; regceb = 1'b1;

      // Reset in the middle of a clear restarts it.
      rst = 1'b1; cyc();
      rst = 1'b0;
      for (int k = 0; k < 7; k++) rand_cycle();
      idle();
      rst = 1'b1;
      for (int c = 0; c < N; c++) bcnt[c] = 0;
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 20; k++) cyc();
      chk("restart_len16", 0, bcnt[0], 32'd16);
      chk("restart_len10", 3, bcnt[3], 32'd10);

      for (int k = 0; k < 150; k++) rand_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
